// File: rtl/operand_fetch.sv
// Operand-read stage between decode and execute. Drives the register file's
// synchronous read ports, bypasses the writeback port over stale register
// reads, forces x0 to zero and keeps held operands current while execute
// stalls.
module operand_fetch #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_addr_rs1,
  output logic [4:0]           rf_addr_rs2,
  input  logic [31:0]          rf_rs1_data,
  input  logic [31:0]          rf_rs2_data,
  input  logic                 wb_we,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_rs1_val,
  output logic [31:0]          out_rs2_val,
  output logic [4:0]           out_rd,
  output logic [PAYLOAD_W-1:0] out_payload
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t state, state_next;

  logic [4:0]           rs1_q, rs2_q, rd_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 byp1_q, byp2_q;
  logic [31:0]          byp1_data_q, byp2_data_q;
  logic [31:0]          op1_q, op2_q;
  logic                 accept;
  logic                 wb_hit1, wb_hit2;
  logic                 wb_hit_in1, wb_hit_in2;
  logic [31:0]          fetch1, fetch2;

  // Writes to x0 never count as a hit, so x0 can never pick up bypass data.
  assign wb_hit1    = wb_we && (wb_addr == rs1_q)  && (rs1_q  != 5'd0);
  assign wb_hit2    = wb_we && (wb_addr == rs2_q)  && (rs2_q  != 5'd0);
  assign wb_hit_in1 = wb_we && (wb_addr == in_rs1) && (in_rs1 != 5'd0);
  assign wb_hit_in2 = wb_we && (wb_addr == in_rs2) && (in_rs2 != 5'd0);

  assign accept = in_valid && in_ready;

  // The read address must lead the data by one cycle, so use the incoming index on accept.
  assign rf_addr_rs1 = accept ? in_rs1 : rs1_q;
  assign rf_addr_rs2 = accept ? in_rs2 : rs2_q;

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush sends any held instruction back to IDLE.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = FETCH;
        FETCH:   state_next = VALID;
        VALID:   if (out_ready) state_next = accept ? FETCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      VALID: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
    if (rst || flush) in_ready = 1'b0;
  end

  // Operand resolution for the FETCH cycle: a coincident write beats an accept-cycle bypass, which beats the register file.
  always_comb begin
    fetch1 = rf_rs1_data;
    fetch2 = rf_rs2_data;
    if (rs1_q == 5'd0)  fetch1 = 32'd0;
    else if (wb_hit1)   fetch1 = wb_data;
    else if (byp1_q)    fetch1 = byp1_data_q;
    if (rs2_q == 5'd0)  fetch2 = 32'd0;
    else if (wb_hit2)   fetch2 = wb_data;
    else if (byp2_q)    fetch2 = byp2_data_q;
  end

  // Instruction latches, accept-cycle bypass capture and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      payload_q   <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      if (accept) begin
        rs1_q       <= in_rs1;
        rs2_q       <= in_rs2;
        rd_q        <= in_rd;
        payload_q   <= in_payload;
        byp1_q      <= wb_hit_in1;
        byp2_q      <= wb_hit_in2;
        byp1_data_q <= wb_data;
        byp2_data_q <= wb_data;
      end
      if (state == FETCH && !flush) begin
        op1_q <= fetch1;
        op2_q <= fetch2;
      end else if (state == VALID) begin
        if (wb_hit1) op1_q <= wb_data;
        if (wb_hit2) op2_q <= wb_data;
      end
    end
  end

  // A write landing while the operands are presented is forwarded straight through.
  always_comb begin
    out_rs1_val = op1_q;
    out_rs2_val = op2_q;
    if (rs1_q == 5'd0)  out_rs1_val = 32'd0;
    else if (wb_hit1)   out_rs1_val = wb_data;
    if (rs2_q == 5'd0)  out_rs2_val = 32'd0;
    else if (wb_hit2)   out_rs2_val = wb_data;
  end

  assign out_rd      = rd_q;
  assign out_payload = payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: a register file model, an architectural
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_payload;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic [31:0] out_payload;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] arch [32];
  logic [31:0] hand_log [$];

  bit          model_on    = 1'b0;
  bit          entry_valid = 1'b0;
  int          cyc         = 0;
  int          vis_cycle   = 0;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] e_payload;

  operand_fetch #(.PAYLOAD_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_payload(in_payload),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_payload(out_payload)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // The newest architectural value of a register, including a write landing this cycle.
  function automatic logic [31:0] archVal(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return arch[idx];
  endfunction

  // Register file (read returns the pre-write value) plus the transaction-level model.
  always @(posedge clk) begin
    bit vis, rdy, acc;
    rf_rs1_data <= arch[rf_addr_rs1];
    rf_rs2_data <= arch[rf_addr_rs2];
    vis = entry_valid && (cyc >= vis_cycle);
    rdy = !rst && !flush && (!entry_valid || (vis && out_ready));
    acc = in_valid && rdy;
    cyc++;
    if (rst) begin
      model_on    = 1'b1;
      entry_valid = 1'b0;
    end else if (flush) begin
      entry_valid = 1'b0;
    end else begin
      if (vis && out_ready) entry_valid = 1'b0;
      if (acc) begin
        entry_valid = 1'b1;
        vis_cycle   = cyc + 1;
        e_rs1 = in_rs1; e_rs2 = in_rs2; e_rd = in_rd; e_payload = in_payload;
      end
    end
    if (!rst && out_valid && out_ready && !flush) hand_log.push_back(out_payload);
    if (wb_we && wb_addr != 5'd0) arch[wb_addr] = wb_data;
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (model_on) begin
      bit vis;
      vis = entry_valid && (cyc >= vis_cycle);
      checkOutput("m_out_valid", {31'd0, out_valid}, {31'd0, vis});
      checkOutput("m_in_ready", {31'd0, in_ready},
                  {31'd0, !rst && !flush && (!entry_valid || (vis && out_ready))});
      if (vis) begin
        checkOutput("m_rs1_val", out_rs1_val, archVal(e_rs1));
        checkOutput("m_rs2_val", out_rs2_val, archVal(e_rs2));
        checkOutput("m_rd", {27'd0, out_rd}, {27'd0, e_rd});
        checkOutput("m_payload", out_payload, e_payload);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic fl, input logic v,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic [31:0] pl,
                               input logic ordy, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; flush = fl; in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d;
    in_payload = pl; out_ready = ordy; wb_we = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    arch[5] = 32'h1234;
    arch[7] = 32'h1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_payload = '0; out_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_rs1_val", out_rs1_val, 32'd0);
    checkOutput("rst_payload", out_payload, 32'd0);

    // Basic read of x5 with rs2 = x0.
    applyStimulus(0, 0, 1, 5'd5, 5'd0, 5'd9, 32'h100, 1, 0, 5'd0, 32'd0);
    checkOutput("t1_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t1_fetch_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_rs1", out_rs1_val, 32'h1234);
    checkOutput("t1_rs2", out_rs2_val, 32'd0);
    checkOutput("t1_rd", {27'd0, out_rd}, 32'd9);
    checkOutput("t1_payload", out_payload, 32'h100);

    // Write to x7 in the accept cycle.
    applyStimulus(0, 0, 1, 5'd7, 5'd5, 5'd1, 32'h200, 1, 1, 5'd7, 32'hAAAA);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t2_rs1", out_rs1_val, 32'hAAAA);
    checkOutput("t2_rs2", out_rs2_val, 32'h1234);

    // Write to x3 during FETCH, then again while stalled.
    applyStimulus(0, 0, 1, 5'd0, 5'd3, 5'd2, 32'h300, 0, 0, 5'd0, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1, 5'd3, 32'hBEEF);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("t3_rs2_fetchwr", out_rs2_val, 32'hBEEF);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1, 5'd3, 32'hC0DE);
    checkOutput("t3_rs2_coincident", out_rs2_val, 32'hC0DE);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("t3_rs2_held", out_rs2_val, 32'hC0DE);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);

    // Writes to x0 must never reach an x0 operand.
    applyStimulus(0, 0, 1, 5'd0, 5'd0, 5'd3, 32'h400, 1, 1, 5'd0, 32'hFFFF);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1, 5'd0, 32'hFFFF);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1, 5'd0, 32'hFFFF);
    checkOutput("t4_x0_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t4_x0_rs1", out_rs1_val, 32'd0);

    // Stall for three cycles, then hand off with a back-to-back accept.
    applyStimulus(0, 0, 1, 5'd5, 5'd7, 5'd4, 32'h500, 0, 0, 5'd0, 32'd0);
    applyStimulus(0, 0, 1, 5'd3, 5'd0, 5'd6, 32'h600, 0, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 5'd3, 5'd0, 5'd6, 32'h600, 0, 0, 5'd0, 32'd0);
      checkOutput("t5_stall_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("t5_stall_payload", out_payload, 32'h500);
    end
    checkOutput("t5_stall_rs2", out_rs2_val, 32'hAAAA);
    applyStimulus(0, 0, 1, 5'd3, 5'd0, 5'd6, 32'h600, 1, 0, 5'd0, 32'd0);
    checkOutput("t5_b2b_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t5_b2b_payload", out_payload, 32'h500);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t5_second_fetch", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t5_second_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t5_second_payload", out_payload, 32'h600);
    checkOutput("t5_second_rs1", out_rs1_val, 32'hC0DE);

    // Flush during FETCH.
    applyStimulus(0, 0, 1, 5'd5, 5'd5, 5'd8, 32'h700, 1, 0, 5'd0, 32'd0);
    applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t6_flush_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t6_after_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_after_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    checkOutput("t6_still_idle", {31'd0, out_valid}, 32'd0);

    // Reset while presenting a valid instruction.
    applyStimulus(0, 0, 1, 5'd5, 5'd7, 5'd4, 32'h800, 0, 0, 5'd0, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("t7_valid_before", {31'd0, out_valid}, 32'd1);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("t7_rst_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("t7_valid_after", {31'd0, out_valid}, 32'd0);
    checkOutput("t7_rs1_after", out_rs1_val, 32'd0);
    checkOutput("t7_rd_after", {27'd0, out_rd}, 32'd0);
    checkOutput("t7_payload_after", out_payload, 32'd0);

    // Each handed-off payload appears exactly once and in order.
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checkOutput("hand_count", hand_log.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] got;
      got = (i < hand_log.size()) ? hand_log[i] : 32'hDEAD_DEAD;
      checkOutput("hand_order", got, 32'h100 * (i + 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
